uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It captures each received byte on the rising edge of the receiver's rx_done and stores it in a circular FIFO. The host drains the FIFO through a registered read handshake. The block also reports level, almost-full, sticky overrun and idle-timeout status for interrupt/polling logic.

Parameters:
DATA_W, 8, width of received byte and FIFO word
DEPTH, 16, number of FIFO entries (power of two)
ADDR_W, 4, log2(DEPTH); pointer width
AFULL_THRESH, 12, level at or above which almost_full asserts
TIMEOUT_CYC, 26050, idle clocks (≈10 bit times at 2605 clk/bit) before timeout asserts

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_done  input  1  byte-complete flag from receiver; may stay high several cycles
rx_data  input  DATA_W  received byte; stable while rx_done high
rd_en  input  1  host read request
rd_data  output  DATA_W  byte read out, registered
rd_valid  output  1  one-cycle pulse: rd_data updated this cycle
empty  output  1  FIFO holds zero entries
full  output  1  FIFO holds DEPTH entries
almost_full  output  1  level >= AFULL_THRESH
level  output  ADDR_W+1  current entry count, 0..DEPTH
overrun  output  1  sticky: a byte was dropped because FIFO full
ovr_clr  input  1  clears overrun
timeout  output  1  sticky: FIFO non-empty and no write/read for TIMEOUT_CYC clocks

Behaviour:
- Reset (reset asynchronous, active-high; clock clk): wr_ptr=rd_ptr=0, level=0, rd_data=0, rd_valid=0, empty=1, full=0, almost_full=0, overrun=0, timeout=0, rx_done_q=0, idle counter=0. Reset mid-transfer discards all contents; no partial state survives.
- Capture: rx_done_q <= rx_done each clk. wr_stb = rx_done & ~rx_done_q. Exactly one write per rx_done rising edge regardless of its high duration. rx_data is sampled in the wr_stb cycle.
- Write: if wr_stb and (!full or rd_accept): mem[wr_ptr] <= rx_data; wr_ptr increments modulo DEPTH (natural ADDR_W-bit wrap).
- Read: rd_accept = rd_en & !empty. On rd_accept: rd_data <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; rd_valid=1 the next cycle (1-cycle latency). rd_en while empty is ignored: rd_valid stays 0 and rd_data holds its value.
- Level: level +1 on write-only, −1 on read-only, unchanged on simultaneous write+read. empty=(level==0), full=(level==DEPTH), almost_full=(level>=AFULL_THRESH). All three are registered or derived from the registered level; they reflect the post-update count the cycle after the event.
- Simultaneous events:
  - wr_stb+rd_accept when full: both performed; level stays DEPTH; no overrun.
  - wr_stb+rd_en when empty: write performed, read ignored; level becomes 1.
- Overrun: wr_stb while full and no rd_accept drops the byte; memory and pointers are unchanged; overrun <= 1. ovr_clr clears overrun. If set and clear coincide, set wins.
- Timeout: the idle counter resets to 0 on wr_stb, on rd_accept, or while empty. Otherwise it increments and saturates at TIMEOUT_CYC. timeout <= 1 when the counter reaches TIMEOUT_CYC−1 while non-empty. timeout clears on the next wr_stb, rd_accept or empty condition.
- Counter width is ceil(log2(TIMEOUT_CYC+1)). No arithmetic overflow is permitted.

Test Plan:
- Write 0xA5 with rx_done held high 3 clks -> exactly one entry; level=1, empty=0. rd_en 1 clk -> next clk rd_valid=1, rd_data=0xA5, then level=0, empty=1.
- Write 0x00..0x0F (16 bytes) -> full=1, level=16, almost_full=1 from the 12th write. A 17th byte 0xFF -> overrun=1, level=16. Drain 16 reads -> data 0x00..0x0F in order, no 0xFF.
- Pointer wrap: write 10, read 10, write 10, read 10 -> outputs match input order; level returns to 0.
- Full plus simultaneous wr_stb (0x77) and rd_en -> oldest byte read, 0x77 stored, level stays 16, overrun stays 0. With ovr_clr and an overrun event in the same cycle -> overrun=1.
- Write 1 byte, idle 26050 clks -> timeout=1. rd_en -> timeout=0 next clk.
- Assert reset mid-stream with level=7 -> outputs immediately at reset values. After release, rd_en gives no rd_valid.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer that sits after the UART receiver.
// Each rising edge of rx_done stores one byte in a circular FIFO. The host
// drains the FIFO through a registered read with one cycle of latency. The
// block also reports the fill level, almost-full, a sticky overrun flag and an
// idle-timeout flag.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   rx_done, rx_data    byte-complete flag and byte from the receiver
//   rd_en               host read request
//   rd_data, rd_valid   registered read byte and its one-cycle strobe
//   empty, full         FIFO holds 0 / DEPTH entries
//   almost_full         level >= AFULL_THRESH
//   level               entry count, 0..DEPTH
//   overrun, ovr_clr    sticky flag for a dropped byte, and its clear
//   timeout             sticky flag: FIFO non-empty and idle for TIMEOUT_CYC clocks
module uart_rx_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12,
  parameter int TIMEOUT_CYC  = 26050
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  idle_cnt;
  logic              rx_done_q;
  logic              wr_stb, rd_accept, wr_do, ovr_set;

  // One write per rising edge of rx_done, however long it stays high.
  assign wr_stb    = rx_done & ~rx_done_q;
  assign rd_accept = rd_en & ~empty;
  // A read in the same cycle frees a slot, so a full FIFO can still take the byte.
  assign wr_do     = wr_stb & (~full | rd_accept);
  assign ovr_set   = wr_stb & full & ~rd_accept;

  assign empty       = (level == '0);
  assign full        = (level == FULL_LVL);
  assign almost_full = (level >= AFULL_LVL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overrun   <= 1'b0;
      idle_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      rd_valid  <= rd_accept;
      if (wr_do) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_accept) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      case ({wr_do, rd_accept})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      // Set has priority over clear.
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      // Any traffic, or an empty FIFO, restarts the idle count.
      if (wr_stb | rd_accept | empty) begin
        idle_cnt <= '0;
        timeout  <= 1'b0;
      end else begin
        if (idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + CNT_ONE;
        if (idle_cnt == CNT_PRE) timeout  <= 1'b1;
      end
    end
  end

  // Storage carries no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: a queue-based reference model is checked on
// every clock, alongside a table of hand-written vectors and directed corner
// sequences.
module tb_uart_rx_fifo;
  localparam int TO = 26050;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done, rd_en, ovr_clr;
  logic [7:0] rx_data;
  logic [7:0] rd_data;
  logic       rd_valid, empty, full, almost_full, overrun, timeout;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .almost_full(almost_full), .level(level),
    .overrun(overrun), .ovr_clr(ovr_clr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  logic       m_prev, m_ovr, m_to, m_rdv;
  logic [7:0] m_rdd;
  int         m_idle;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev = 0; m_ovr = 0; m_to = 0; m_rdv = 0; m_rdd = 0; m_idle = 0;
  endtask

  task automatic model_update(input logic d, input logic [7:0] dat, input logic r, input logic c);
    logic stb, acc, was_empty, was_full;
    stb       = d && !m_prev;
    m_prev    = d;
    was_empty = (q.size() == 0);
    was_full  = (q.size() == 16);
    acc       = r && !was_empty;
    m_rdv     = acc;
    if (acc) m_rdd = q.pop_front();
    if (c) m_ovr = 0;
    if (stb) begin
      if (!was_full || acc) q.push_back(dat);
      else m_ovr = 1;
    end
    if (stb || acc || was_empty) begin
      m_idle = 0; m_to = 0;
    end else begin
      if (m_idle == TO - 1) m_to = 1;
      if (m_idle < TO) m_idle++;
    end
  endtask

  task automatic compare_model();
    chk("m_level",    32'(level),       32'(q.size()));
    chk("m_empty",    32'(empty),       32'(q.size() == 0));
    chk("m_full",     32'(full),        32'(q.size() == 16));
    chk("m_afull",    32'(almost_full), 32'(q.size() >= 12));
    chk("m_rd_valid", 32'(rd_valid),    32'(m_rdv));
    chk("m_rd_data",  32'(rd_data),     32'(m_rdd));
    chk("m_overrun",  32'(overrun),     32'(m_ovr));
    chk("m_timeout",  32'(timeout),     32'(m_to));
  endtask

  task automatic step(input logic d, input logic [7:0] dat, input logic r, input logic c);
    @(negedge clk);
    rx_done = d; rx_data = dat; rd_en = r; ovr_clr = c;
    @(posedge clk);
    model_update(d, dat, r, c);
    #1;
    compare_model();
  endtask

  task automatic wr_byte(input logic [7:0] b);
    step(1, b, 0, 0);
    step(0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_done = 0; rd_en = 0; ovr_clr = 0; rx_data = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  typedef struct {
    logic       d;
    logic [7:0] dat;
    logic       r;
    int         exp_level;
    logic       exp_rdv;
    logic [7:0] exp_rdd;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic cur;
    logic [7:0] b;

    vt[0] = '{1, 8'hA5, 0, 1, 0, 8'h00};
    vt[1] = '{1, 8'hA5, 0, 1, 0, 8'h00};
    vt[2] = '{1, 8'hA5, 0, 1, 0, 8'h00};
    vt[3] = '{0, 8'h00, 0, 1, 0, 8'h00};
    vt[4] = '{0, 8'h00, 1, 0, 1, 8'hA5};
    vt[5] = '{0, 8'h00, 0, 0, 0, 8'hA5};
    vt[6] = '{0, 8'h00, 1, 0, 0, 8'hA5};
    vt[7] = '{1, 8'h3C, 0, 1, 0, 8'hA5};
    vt[8] = '{1, 8'h3C, 1, 0, 1, 8'h3C};
    vt[9] = '{0, 8'h00, 1, 0, 0, 8'h3C};

    reset = 1; rx_done = 0; rd_en = 0; ovr_clr = 0; rx_data = 0;
    model_reset();
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_rdv",   32'(rd_valid), 0);
    chk("rst_rdd",   32'(rd_data), 0);
    do_reset();

    // Stretched rx_done, single read, ignored reads while empty.
    foreach (vt[i]) begin
      step(vt[i].d, vt[i].dat, vt[i].r, 0);
      chk("tbl_level", 32'(level),    32'(vt[i].exp_level));
      chk("tbl_rdv",   32'(rd_valid), 32'(vt[i].exp_rdv));
      chk("tbl_rdd",   32'(rd_data),  32'(vt[i].exp_rdd));
    end

    // Fill, almost_full threshold, overrun, in-order drain.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_byte(8'(i));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 12));
    end
    chk("fill_full",  32'(full),  1);
    chk("fill_level", 32'(level), 16);
    wr_byte(8'hFF);
    chk("ovr_set",   32'(overrun), 1);
    chk("ovr_level", 32'(level),   16);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0);
      chk("drain_data", 32'(rd_data), 32'(i));
    end
    chk("drain_empty", 32'(empty), 1);

    // Full with simultaneous write and read, then set/clear collision.
    step(0, 0, 0, 1);
    chk("ovr_clr", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) wr_byte(8'(8'h10 + i));
    step(1, 8'h77, 1, 0);
    chk("sim_rdd",   32'(rd_data), 32'h10);
    chk("sim_level", 32'(level),   16);
    chk("sim_ovr",   32'(overrun), 0);
    step(0, 0, 0, 0);
    step(1, 8'h99, 0, 1);
    chk("ovr_set_wins", 32'(overrun), 1);
    step(0, 0, 0, 0);
    for (int i = 1; i < 16; i++) begin
      step(0, 0, 1, 0);
      chk("sim_drain", 32'(rd_data), 32'(8'h10 + i));
    end
    step(0, 0, 1, 0);
    chk("sim_last", 32'(rd_data), 32'h77);

    // Pointer wrap.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) wr_byte(8'(8'h40 + 16 * k + i));
      for (int i = 0; i < 10; i++) begin
        step(0, 0, 1, 0);
        chk("wrap_data", 32'(rd_data), 32'(8'h40 + 16 * k + i));
      end
      chk("wrap_level", 32'(level), 0);
    end

    // Idle timeout.
    do_reset();
    step(1, 8'h5A, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0);
    chk("to_before", 32'(timeout), 0);
    step(0, 0, 0, 0);
    chk("to_set", 32'(timeout), 1);
    step(0, 0, 1, 0);
    chk("to_clr", 32'(timeout), 0);
    chk("to_rdd", 32'(rd_data), 32'h5A);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 8; i++) wr_byte(8'(8'hC0 + i));
    step(0, 0, 1, 0);
    chk("pre_rst_level", 32'(level),    7);
    chk("pre_rst_rdv",   32'(rd_valid), 1);
    #2 reset = 1;
    #1;
    chk("arst_level", 32'(level),    0);
    chk("arst_empty", 32'(empty),    1);
    chk("arst_rdv",   32'(rd_valid), 0);
    chk("arst_rdd",   32'(rd_data),  0);
    rd_en = 0;
    @(negedge clk);
    reset = 0;
    model_reset();
    step(0, 0, 1, 0);
    chk("post_rst_rdv", 32'(rd_valid), 0);

    // Randomized traffic against the model; phases alternate fill/drain bias.
    cur = 0;
    for (int i = 0; i < 4000; i++) begin
      int rp;
      rp  = ((i / 500) % 2 == 0) ? 15 : 70;
      if ($urandom_range(0, 2) == 0) cur = ~cur;
      b = 8'($urandom);
      step(cur, b, ($urandom_range(0, 99) < rp), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
